// File: rtl/register_file_2r1w.sv
// 32x16 register file with two registered read ports and one write port.
// A read that hits the address being written on the same edge returns the new data.

module register_file_2r1w_rdport #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]     mem,
  input  logic [ADDR_W-1:0]                      rdAddr,
  input  logic                                   rdEn,
  input  logic                                   wrEn,
  input  logic [ADDR_W-1:0]                      wrAddr,
  input  logic [DATA_W-1:0]                      wrData,
  output logic [DATA_W-1:0]                      rdData
);
  logic             bypass;
  logic [DATA_W-1:0] nextData;

  // Write-first: the array still holds the old value on this edge, so forward.
  assign bypass   = wrEn && (wrAddr == rdAddr);
  assign nextData = bypass ? wrData : mem[rdAddr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdData <= '0;
    else if (rdEn) rdData <= nextData;
  end
endmodule

module register_file_2r1w #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read_addA,
  input  logic [ADDR_W-1:0] read_addB,
  input  logic [ADDR_W-1:0] write_addC,
  input  logic [DATA_W-1:0] write_dataC,
  input  logic              enable_A,
  input  logic              enable_B,
  input  logic              enable_C,
  output logic [DATA_W-1:0] read_dataA,
  output logic [DATA_W-1:0] read_dataB
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NUM_RD = 2;

  logic [DEPTH-1:0][DATA_W-1:0]  mem;
  logic [NUM_RD-1:0][ADDR_W-1:0] rdAddr;
  logic [NUM_RD-1:0]             rdEn;
  logic [NUM_RD-1:0][DATA_W-1:0] rdData;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        mem <= '0;
    else if (enable_C) mem[write_addC] <= write_dataC;
  end

  assign rdAddr = {read_addB, read_addA};
  assign rdEn   = {enable_B, enable_A};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    register_file_2r1w_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd (
      .clk    (clk),
      .rst_n  (rst_n),
      .mem    (mem),
      .rdAddr (rdAddr[p]),
      .rdEn   (rdEn[p]),
      .wrEn   (enable_C),
      .wrAddr (write_addC),
      .wrData (write_dataC),
      .rdData (rdData[p])
    );
  end

  assign read_dataA = rdData[0];
  assign read_dataB = rdData[1];
endmodule

// File: tb/tb_register_file_2r1w.sv
// Randomized and directed checks of register_file_2r1w against an array model.

module tb_register_file_2r1w;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  read_addA, read_addB, write_addC;
  logic [15:0] write_dataC;
  logic        enable_A, enable_B, enable_C;
  logic [15:0] read_dataA, read_dataB;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] refMem [32];
  logic [15:0] refA, refB;

  register_file_2r1w dut (
    .clk(clk), .rst_n(rst_n),
    .read_addA(read_addA), .read_addB(read_addB),
    .write_addC(write_addC), .write_dataC(write_dataC),
    .enable_A(enable_A), .enable_B(enable_B), .enable_C(enable_C),
    .read_dataA(read_dataA), .read_dataB(read_dataB)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) refMem[i] = 16'h0;
    refA = 16'h0;
    refB = 16'h0;
  endtask

  // One rising edge; model applies the write first, then the reads see the array.
  task automatic step();
    @(posedge clk);
    if (enable_C) refMem[write_addC] = write_dataC;
    if (enable_A) refA = refMem[read_addA];
    if (enable_B) refB = refMem[read_addB];
    @(negedge clk);
  endtask

  task automatic idle();
    enable_A = 0; enable_B = 0; enable_C = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle();
    read_addA = 0; read_addB = 0; write_addC = 0; write_dataC = 0;
    model_clear();
    #12;
    vectors++;
    if (read_dataA !== 16'h0 || read_dataB !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_out: A=%h B=%h want 0000", read_dataA, read_dataB);
    end
    @(negedge clk); rst_n = 1;
    step();
    enable_A = 1; enable_B = 1; read_addA = 0; read_addB = 31;
    step();
    vectors++;
    if (read_dataA !== 16'h0 || read_dataB !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_read: A=%h B=%h want 0000", read_dataA, read_dataB);
    end
    idle();
  endtask

  task automatic test_enables_low();
    idle();
    read_addA = 1; read_addB = 2; write_addC = 3; write_dataC = 16'h0006;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (read_dataA !== 16'h0 || read_dataB !== 16'h0) begin
        miscompares++;
        $display("FAIL enables_low: cyc %0d A=%h B=%h want 0000", i, read_dataA, read_dataB);
      end
    end
    enable_A = 1; read_addA = 3;
    step();
    vectors++;
    if (read_dataA !== 16'h0) begin
      miscompares++;
      $display("FAIL no_write_addr3: A=%h want 0000", read_dataA);
    end
    idle();
  endtask

  task automatic test_write_read();
    enable_C = 1;
    write_addC = 3; write_dataC = 16'h0006; step();
    write_addC = 5; write_dataC = 16'h1234; step();
    write_addC = 6; write_dataC = 16'hBEEF; step();
    enable_C = 0; enable_A = 1; enable_B = 1; read_addA = 5; read_addB = 6;
    step();
    vectors++;
    if (read_dataA !== 16'h1234 || read_dataB !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL write_read: A=%h B=%h want 1234 beef", read_dataA, read_dataB);
    end
    read_addA = 6; read_addB = 6;
    step();
    vectors++;
    if (read_dataA !== 16'hBEEF || read_dataB !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL same_addr: A=%h B=%h want beef beef", read_dataA, read_dataB);
    end
    idle();
  endtask

  task automatic test_bypass();
    enable_C = 1; write_addC = 7; write_dataC = 16'h0001; step();
    write_dataC = 16'h00AA; enable_A = 1; read_addA = 7;
    enable_B = 1; read_addB = 7;
    step();
    vectors++;
    if (read_dataA !== 16'h00AA || read_dataB !== 16'h00AA) begin
      miscompares++;
      $display("FAIL bypass: A=%h B=%h want 00aa", read_dataA, read_dataB);
    end
    idle();
  endtask

  task automatic test_hold();
    enable_B = 1; read_addB = 3; step();
    vectors++;
    if (read_dataB !== 16'h0006) begin
      miscompares++;
      $display("FAIL hold_load: B=%h want 0006", read_dataB);
    end
    enable_B = 0; read_addB = 5;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (read_dataB !== 16'h0006) begin
        miscompares++;
        $display("FAIL hold: cyc %0d B=%h want 0006", i, read_dataB);
      end
    end
    idle();
  endtask

  task automatic test_sweep();
    logic [15:0] expA, expB;
    enable_C = 1;
    for (int i = 0; i < 32; i++) begin
      write_addC = 5'(i); write_dataC = 16'(i * 16'h0101); step();
    end
    enable_C = 0; enable_A = 1; enable_B = 1;
    for (int i = 0; i < 32; i++) begin
      read_addA = 5'(i); read_addB = 5'(31 - i);
      step();
      expA = 16'(i * 16'h0101);
      expB = 16'((31 - i) * 16'h0101);
      vectors++;
      if (read_dataA !== expA || read_dataB !== expB) begin
        miscompares++;
        $display("FAIL sweep: i=%0d A=%h B=%h want %h %h", i, read_dataA, read_dataB, expA, expB);
      end
    end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      enable_A = 1'($urandom); enable_B = 1'($urandom); enable_C = 1'($urandom);
      // Narrow address range so same-address collisions and bypasses happen often.
      read_addA  = 5'($urandom_range(0, 7));
      read_addB  = 5'($urandom_range(0, 7));
      write_addC = (n % 3 == 0) ? read_addA : 5'($urandom_range(0, 7));
      write_dataC = 16'($urandom);
      step();
      vectors++;
      if (read_dataA !== refA || read_dataB !== refB) begin
        miscompares++;
        $display("FAIL random: n=%0d A=%h B=%h want %h %h", n, read_dataA, read_dataB, refA, refB);
      end
    end
    idle();
  endtask

  task automatic test_reset_midrun();
    enable_A = 1; enable_B = 1; enable_C = 1;
    read_addA = 1; read_addB = 2; write_addC = 4; write_dataC = 16'h5A5A;
    #2 rst_n = 0;
    #1;
    vectors++;
    if (read_dataA !== 16'h0 || read_dataB !== 16'h0) begin
      miscompares++;
      $display("FAIL midrun_reset: A=%h B=%h want 0000", read_dataA, read_dataB);
    end
    model_clear();
    @(negedge clk); @(negedge clk);
    idle(); rst_n = 1;
    enable_A = 1; enable_B = 1;
    for (int i = 0; i < 32; i += 4) begin
      read_addA = 5'(i); read_addB = 5'(i + 1);
      step();
      vectors++;
      if (read_dataA !== 16'h0 || read_dataB !== 16'h0) begin
        miscompares++;
        $display("FAIL post_reset: addr %0d A=%h B=%h want 0000", i, read_dataA, read_dataB);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_enables_low();
    test_write_read();
    test_bypass();
    test_hold();
    test_sweep();
    test_random();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/register_file_2r1w.md
Name:
register_file_2r1w

Overview:
- Register file for the 16-bit RISC datapath: 32 entries x 16 bits.
- Two synchronous read ports (A, B) and one synchronous write port (C), each with its own enable.
- Sits between instruction decode (supplies addresses) and the ALU/writeback stage (consumes read data, supplies write data).

Parameters:
- DATA_W, 16, width of each register and of the data ports.
- ADDR_W, 5, address width; depth = 2**ADDR_W = 32 entries.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- read_addA  input  ADDR_W  port A read address.
- read_addB  input  ADDR_W  port B read address.
- write_addC  input  ADDR_W  port C write address.
- write_dataC  input  DATA_W  port C write data.
- enable_A  input  1  port A read enable.
- enable_B  input  1  port B read enable.
- enable_C  input  1  port C write enable.
- read_dataA  output  DATA_W  port A registered read data.
- read_dataB  output  DATA_W  port B registered read data.

Behaviour:
- **Interface:** one clock; reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.
- **Reset:**
  - While rst_n = 0, all 32 registers, read_dataA and read_dataB are forced to 0 immediately, independent of clk.
  - After rst_n deasserts, normal operation starts at the next rising clk edge.
- **Write:**
  - On a rising clk edge with enable_C = 1, mem[write_addC] <= write_dataC.
  - With enable_C = 0, no register changes.
- **Read port A:**
  - On a rising clk edge with enable_A = 1, read_dataA <= mem[read_addA].
  - With enable_A = 0, read_dataA holds its previous value.
  - Read latency is 1 cycle: data for an address sampled at edge N is visible after edge N.
- **Read port B:** identical to port A, using read_addB, enable_B and read_dataB.
- **All 32 entries** are ordinary writable registers; there is no hardwired-zero register.
- **Read-during-write, same edge and same address** (enable_C = 1, enable_X = 1, read_addX == write_addC): write-first bypass. read_dataX gets write_dataC, the new value.
- **Both read ports** may address the same entry simultaneously; both return the same value.
- **Enables are independent.** Any combination of enable_A/B/C is legal in any cycle.
- **No X propagation:** every register is reset, so reads before any write return 0.
- **Outputs change** only on a rising clk edge or on reset assertion.

Test Plan:
- **Reset:** assert rst_n = 0 mid-run with enables high -> read_dataA = read_dataB = 0 immediately. After release, reading any address returns 0x0000.
- **Enables low:** enable_A = enable_B = enable_C = 0, read_addA = 1, read_addB = 2, write_addC = 3, write_dataC = 0x0006 for several cycles -> outputs stay 0x0000. A later read of address 3 returns 0x0000 (no write occurred).
- **Write then read:** enable_C = 1, write 0x0006 to address 3, then 0x1234 to address 5 and 0xBEEF to address 6. Then enable_A = enable_B = 1 with read_addA = 5, read_addB = 6 -> one cycle later read_dataA = 0x1234, read_dataB = 0xBEEF.
- **Write-first bypass:** mem[7] = 0x0001, then in one edge write_addC = 7, write_dataC = 0x00AA with read_addA = 7, enable_A = 1 -> read_dataA = 0x00AA after that edge.
- **Hold:** read address 3 (value 0x0006) on port B, then drop enable_B and change read_addB to 5 -> read_dataB stays 0x0006.
- **Full sweep:** write mem[i] = i*0x0101 for i = 0..31, then read all 32 addresses on both ports -> each returns i*0x0101 (mod 2^16) one cycle after its address is presented.
